// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_TX among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to add the start-bit timeout and the sticky err port.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int TIMEOUT_CYC = 4 * (CLK_FREQ / BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_newd,
  output logic [7:0]           tx_data,
  input  logic                 tx_line,
  input  logic                 tx_donetx,
  output logic [2:0]           grant_id,
  output logic                 busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                 err
`endif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, SEND, ACK} state_t;
  state_t state_q, state_d;
  logic tx_newd_q, tx_newd_d, busy_q, busy_d, line_q, done_q;
  logic [7:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [2:0] grant_id_q, grant_id_d;
  logic [IW-1:0] idx, win;
  logic found, fall, rise;
  if (CLK_FREQ / BAUD_RATE < 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: CLK_FREQ/BAUD_RATE must be at least 8");
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign err = err_q;
`endif
  assign fall = line_q & ~tx_line;
  assign rise = ~done_q & tx_donetx;
  // search starts just after the last grant, so the last served requester ranks lowest
  always_comb begin
    idx = '0;
    win = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(grant_id_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    tx_newd_d = tx_newd_q;
    tx_data_d = tx_data_q;
    req_ack_d = '0;
    grant_id_d = grant_id_q;
    busy_d = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    err_d = err_q;
    cnt_d = (state_q == LAUNCH) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: state_d = |req_valid ? ARB : IDLE;
      ARB: begin
        state_d = found ? LAUNCH : IDLE;
        tx_data_d = found ? req_data[8*win +: 8] : tx_data_q;
        grant_id_d = found ? 3'(win) : grant_id_q;
        busy_d = found;
        tx_newd_d = found;
      end
      LAUNCH: begin
        if (fall) begin
          tx_newd_d = 1'b0;
          state_d = SEND;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tx_newd_d = 1'b0;
          err_d = 1'b1;
          req_ack_d = NUM_REQ'(1) << grant_id_q;
          busy_d = 1'b0;
          state_d = ACK;
        end
`endif
      end
      SEND: begin
        // donetx stays high for a whole bit period, so only its rising edge counts
        if (rise) begin
          req_ack_d = NUM_REQ'(1) << grant_id_q;
          busy_d = 1'b0;
          state_d = ACK;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_newd_q <= 1'b0;
      tx_data_q <= '0;
      req_ack_q <= '0;
      grant_id_q <= 3'(NUM_REQ - 1);
      busy_q <= 1'b0;
      line_q <= 1'b1;
      done_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_newd_q <= tx_newd_d;
      tx_data_q <= tx_data_d;
      req_ack_q <= req_ack_d;
      grant_id_q <= grant_id_d;
      busy_q <= busy_d;
      line_q <= tx_line;
      done_q <= tx_donetx;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign tx_newd = tx_newd_q;
  assign tx_data = tx_data_q;
  assign req_ack = req_ack_q;
  assign grant_id = grant_id_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a small UART_TX model and an independent serial decoder.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int CPB = 16;
  localparam int TOC = 4 * CPB;
  logic clk = 1'b0, rst = 1'b1, hold_hi = 1'b0;
  logic [NR-1:0] req_valid = '0, req_ack, rearm = '0;
  logic [8*NR-1:0] req_data = '0;
  logic tx_newd, busy, tx_line_w, m_line, m_done;
  logic [7:0] tx_data, m_sh, d_sh;
  logic [2:0] grant_id;
  logic [3:0] m_bit;
  logic [1:0] m_st;
  int m_div, d_cnt, n_chk = 0, n_fail = 0;
  int ack_cnt[NR];
  logic d_act, d_prev, d_bad;
  logic [8:0] rx_q[$];
  logic [NR-1:0] a;
  logic [8:0] b;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic err;
`endif
  always #5 clk = ~clk;
  assign tx_line_w = m_line | hold_hi;
  uart_tx_arbiter #(.NUM_REQ(NR), .CLK_FREQ(160000), .BAUD_RATE(10000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .tx_newd(tx_newd), .tx_data(tx_data), .tx_line(tx_line_w), .tx_donetx(m_done),
    .grant_id(grant_id), .busy(busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );
  // UART_TX stand-in: one bit per CPB clocks, donetx high for the stop bit
  always @(posedge clk) begin
    if (rst) begin
      m_line <= 1'b1; m_done <= 1'b0; m_st <= 2'd0; m_div <= 0; m_bit <= 4'd0; m_sh <= 8'h00;
    end else begin
      m_div <= (m_div == CPB - 1) ? 0 : m_div + 1;
      if (m_div == CPB - 1)
        case (m_st)
          2'd0: if (tx_newd) begin m_sh <= tx_data; m_line <= 1'b0; m_st <= 2'd1; m_bit <= 4'd0; end
          2'd1: if (m_bit < 4'd8) begin m_line <= m_sh[m_bit[2:0]]; m_bit <= m_bit + 4'd1; end
                else begin m_line <= 1'b1; m_done <= 1'b1; m_st <= 2'd2; end
          default: begin m_done <= 1'b0; m_st <= 2'd0; end
        endcase
    end
  end
  // serial decoder: samples mid-bit, bit 8 of a pushed entry flags a framing error
  always @(posedge clk) begin
    if (rst) begin
      d_act <= 1'b0; d_prev <= 1'b1; d_cnt <= 0; d_bad <= 1'b0;
    end else begin
      d_prev <= tx_line_w;
      if (!d_act && d_prev && !tx_line_w) begin
        d_act <= 1'b1; d_cnt <= 0; d_bad <= 1'b0;
      end else if (d_act) begin
        d_cnt <= d_cnt + 1;
        if (d_cnt % CPB == CPB / 2 - 2) begin
          if (d_cnt / CPB == 0) d_bad <= tx_line_w;
          else if (d_cnt / CPB <= 8) d_sh <= {tx_line_w, d_sh[7:1]};
          else begin rx_q.push_back({d_bad | ~tx_line_w, d_sh}); d_act <= 1'b0; end
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (req_ack[i]) ack_cnt[i]++;
    req_valid = (req_valid & ~req_ack) | (req_ack & rearm);
    rearm = rearm & ~req_ack;
  endtask
  task automatic wait_ack(output logic [NR-1:0] r);
    r = '0;
    for (int n = 0; n < 600 && r == '0; n++) begin
      tick();
      r = req_ack;
    end
  endtask
  task automatic wait_rx(output logic [8:0] r);
    r = 9'h1ff;
    for (int n = 0; n < 600 && rx_q.size() == 0; n++) tick();
    if (rx_q.size() != 0) r = rx_q.pop_front();
  endtask
  task automatic wait_newd(input logic v);
    for (int n = 0; n < 600 && tx_newd !== v; n++) tick();
    check("newd_wait", 32'(tx_newd), 32'(v));
  endtask
  task automatic clr();
    rx_q.delete();
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
  endtask
  initial begin
    clr();
    repeat (3) tick();
    check("rst_newd", 32'(tx_newd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(req_ack), 0);
    check("rst_grant", 32'(grant_id), 3);
    check("rst_data", 32'(tx_data), 0);
    rst = 1'b0;
    repeat (2) tick();
    req_valid = 4'b0001; req_data[7:0] = 8'hA5;
    tick();
    check("t1_newd_1cyc", 32'(tx_newd), 0);
    tick();
    check("t1_newd_2cyc", 32'(tx_newd), 1);
    check("t1_data", 32'(tx_data), 32'hA5);
    check("t1_grant", 32'(grant_id), 0);
    check("t1_busy", 32'(busy), 1);
    wait_ack(a);
    check("t1_ack", 32'(a), 32'b0001);
    check("t1_busy_ack", 32'(busy), 0);
    wait_rx(b);
    check("t1_line", 32'(b), 32'h0A5);
    repeat (40) tick();
    check("t1_ack_once", 32'(ack_cnt[0]), 1);
    check("t1_grant_end", 32'(grant_id), 0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    clr();
    req_data = 32'h44332211;
    req_valid = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      wait_ack(a);
      check("t2_ack_order", 32'(a), 32'(1 << k));
      check("t2_grant", 32'(grant_id), 32'(k));
      check("t2_busy_ack", 32'(busy), 0);
    end
    repeat (40) tick();
    for (int k = 0; k < NR; k++) begin
      wait_rx(b);
      check("t2_byte", 32'(b), 32'(8'h11 * (k + 1)));
      check("t2_ack_once", 32'(ack_cnt[k]), 1);
    end
    clr();
    req_data = {8'h3A, 8'h5C, 16'h0000};
    req_valid = 4'b1100; rearm = 4'b0100;
    wait_ack(a);
    check("t3_first", 32'(a), 32'b0100);
    req_data[23:16] = 8'hC5;
    wait_ack(a);
    check("t3_second", 32'(a), 32'b1000);
    wait_ack(a);
    check("t3_third", 32'(a), 32'b0100);
    wait_rx(b); check("t3_byte0", 32'(b), 32'h05C);
    wait_rx(b); check("t3_byte1", 32'(b), 32'h03A);
    wait_rx(b); check("t3_byte2", 32'(b), 32'h0C5);
    repeat (10) tick();
    clr();
    req_valid = 4'b0010; req_data[15:8] = 8'h96;
    wait_newd(1'b1);
    wait_newd(1'b0);
    req_valid = 4'b0000; req_data[15:8] = 8'hFF;
    wait_ack(a);
    check("t4_ack", 32'(a), 32'b0010);
    check("t4_grant", 32'(grant_id), 1);
    wait_rx(b);
    check("t4_byte", 32'(b), 32'h096);
    repeat (10) tick();
    clr();
    req_valid = 4'b1000; req_data[31:24] = 8'h55;
    wait_newd(1'b1);
    wait_newd(1'b0);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check("t5_newd", 32'(tx_newd), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_ack", 32'(req_ack), 0);
    check("t5_grant", 32'(grant_id), 3);
    repeat (3 * CPB) tick();
    check("t5_line_idle", 32'(tx_line_w), 1);
    check("t5_no_stale", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]), 0);
    rx_q.delete();
    req_valid = 4'b1001; req_data = 32'hF000000F;
    rst = 1'b0;
    wait_ack(a);
    check("t5_first", 32'(a), 32'b0001);
    wait_ack(a);
    check("t5_second", 32'(a), 32'b1000);
    wait_rx(b); check("t5_byte0", 32'(b), 32'h00F);
    wait_rx(b); check("t5_byte1", 32'(b), 32'h0F0);
    repeat (10) tick();
    clr();
    hold_hi = 1'b1;
    req_valid = 4'b0010;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wait_ack(a);
    check("t6_ack", 32'(a), 32'b0010);
    check("t6_err", 32'(err), 1);
    check("t6_newd", 32'(tx_newd), 0);
    repeat (10) tick();
    check("t6_err_sticky", 32'(err), 1);
`else
    repeat (2 * TOC + 10) tick();
    check("t6_newd_held", 32'(tx_newd), 1);
    check("t6_busy", 32'(busy), 1);
    check("t6_no_ack", 32'(ack_cnt[1]), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
